// File: rtl/delay_mem_arbiter_pkg.sv
// Shared types and helpers for the delay-line memory arbiter and the other round-robin arbiters.
package delay_mem_arbiter_pkg;

    localparam int DELAY_ARB_MIN_LATENCY = 1;

    // Wide enough for up to 16 requesters; narrower arbiters just use the low codes.
    localparam int REQ_IDX_W = 4;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef struct packed {
        logic     valid;
        req_idx_t requester;
    } delay_tag_t;

    function automatic req_idx_t rr_next(req_idx_t idx, int n);
        if (int'(idx) >= n - 1) return '0;
        return idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/delay_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request after 'last', returned one-hot.
module rr_picker
    import delay_mem_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         last,
    output logic [N_REQ-1:0] winner,
    output req_idx_t         winner_idx,
    output logic             found
);

    req_idx_t scan_idx;

    always_comb begin
        winner     = '0;
        winner_idx = last;
        found      = 1'b0;
        scan_idx   = last;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = rr_next(scan_idx, N_REQ);
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && scan_idx == req_idx_t'(j)) begin
                    winner[j]  = 1'b1;
                    winner_idx = scan_idx;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/delay_mem_arbiter.sv
// Round-robin arbiter sharing the single-port delay-line SRAM between pipelines.
// Define DELAY_MEM_BOUNDS_EN to add per-requester region relocation and bounds checking.
module delay_mem_arbiter
    import delay_mem_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [N_REQ-1:0]            rvalid,
    input  logic [N_REQ-1:0]            flush,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    input  logic [N_REQ-1:0]            alloc_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] alloc_size,
    input  logic [N_REQ*DATA_WIDTH-1:0] alloc_base,
    output logic [N_REQ-1:0]            bounds_err
);

    localparam int TAG_DEPTH = (MEM_LATENCY < DELAY_ARB_MIN_LATENCY) ? DELAY_ARB_MIN_LATENCY : MEM_LATENCY;

    req_idx_t              last;
    delay_tag_t            tags [TAG_DEPTH];
    delay_tag_t            issue_tag;
    delay_tag_t            ret_tag;
    logic [N_REQ-1:0]      req_masked;
    logic [N_REQ-1:0]      winner;
    req_idx_t              winner_idx;
    logic                  found;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [ADDR_WIDTH-1:0] phys_addr;
    logic                  in_range;

    function automatic delay_tag_t drop_flushed(delay_tag_t t, logic [N_REQ-1:0] f);
        drop_flushed = t;
        for (int i = 0; i < N_REQ; i++) begin
            if (f[i] && t.requester == req_idx_t'(i)) drop_flushed.valid = 1'b0;
        end
    endfunction

    function automatic logic [N_REQ-1:0] tag_onehot(delay_tag_t t);
        tag_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (t.valid && t.requester == req_idx_t'(i)) tag_onehot[i] = 1'b1;
        end
    endfunction

    // Last cycle's grantee still holds req high, so it sits out one round.
    assign req_masked = req & ~grant & ~flush;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req        (req_masked),
        .last       (last),
        .winner     (winner),
        .winner_idx (winner_idx),
        .found      (found)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                sel_we    = sel_we | req_we[i];
                sel_addr  = sel_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = sel_wdata | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef DELAY_MEM_BOUNDS_EN
    localparam int CW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

    logic [DATA_WIDTH-1:0] region_base [N_REQ];
    logic [DATA_WIDTH-1:0] region_size [N_REQ];
    logic [CW-1:0]         off_ext;
    logic [CW-1:0]         base_ext;
    logic [CW-1:0]         size_ext;
    logic [CW-1:0]         addr_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                region_base[i] <= '0;
                region_size[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (alloc_valid[i]) begin
                    region_base[i] <= alloc_base[i*DATA_WIDTH +: DATA_WIDTH];
                    region_size[i] <= alloc_size[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Checked against the region as it stands this cycle; a same-cycle alloc applies next cycle.
    always_comb begin
        base_ext = '0;
        size_ext = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner[i]) begin
                base_ext = base_ext | CW'(region_base[i]);
                size_ext = size_ext | CW'(region_size[i]);
            end
        end
        off_ext   = CW'(sel_addr);
        addr_sum  = base_ext + off_ext;
        in_range  = off_ext < size_ext;
        phys_addr = addr_sum[ADDR_WIDTH-1:0];
    end
`else
    logic unused_alloc;
    assign unused_alloc = ^{alloc_valid, alloc_size, alloc_base};
    assign in_range     = 1'b1;
    assign phys_addr    = sel_addr;
`endif

    always_comb begin
        issue_tag.valid     = mem_en & ~mem_we;
        issue_tag.requester = last;
        ret_tag             = drop_flushed(tags[TAG_DEPTH-1], flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            bounds_err <= '0;
            rvalid     <= '0;
            rdata      <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            last       <= req_idx_t'(N_REQ - 1);
            for (int k = 0; k < TAG_DEPTH; k++) tags[k] <= '0;
        end else begin
            grant      <= found ? winner : '0;
            bounds_err <= (found && !in_range) ? winner : '0;
            mem_en     <= found && in_range;
            mem_we     <= found && in_range && sel_we;
            if (found && in_range) begin
                mem_addr  <= phys_addr;
                mem_wdata <= sel_wdata;
            end
            if (found) last <= winner_idx;

            tags[0] <= drop_flushed(issue_tag, flush);
            for (int k = 1; k < TAG_DEPTH; k++) tags[k] <= drop_flushed(tags[k-1], flush);

            rvalid <= tag_onehot(ret_tag);
            if (ret_tag.valid) rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Directed self-checking bench for delay_mem_arbiter against a 2-cycle SRAM model returning addr+0x100.
module tb_delay_mem_arbiter;

    localparam int N_REQ       = 2;
    localparam int ADDR_WIDTH  = 18;
    localparam int DATA_WIDTH  = 16;
    localparam int MEM_LATENCY = 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            req_we;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]            grant;
    logic [DATA_WIDTH-1:0]       rdata;
    logic [N_REQ-1:0]            rvalid;
    logic [N_REQ-1:0]            flush;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic [DATA_WIDTH-1:0]       mem_rdata = '0;
    logic [DATA_WIDTH-1:0]       mem_stage = '0;
    logic [N_REQ-1:0]            alloc_valid;
    logic [N_REQ*DATA_WIDTH-1:0] alloc_size;
    logic [N_REQ*DATA_WIDTH-1:0] alloc_base;
    logic [N_REQ-1:0]            bounds_err;

    int checks = 0;
    int errors = 0;

    delay_mem_arbiter #(
        .N_REQ(N_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_LATENCY(MEM_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .grant(grant), .rdata(rdata), .rvalid(rvalid), .flush(flush),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .alloc_valid(alloc_valid), .alloc_size(alloc_size),
        .alloc_base(alloc_base), .bounds_err(bounds_err)
    );

    always #5 clk = ~clk;

    // Data for an access presented in cycle c is valid on mem_rdata in cycle c+2.
    always @(posedge clk) begin
        mem_stage <= mem_addr[DATA_WIDTH-1:0] + 16'h0100;
        mem_rdata <= mem_stage;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        flush = '0; alloc_valid = '0; alloc_size = '0; alloc_base = '0;
        step(); step();
        checks++;
        if ({grant, rvalid, bounds_err, mem_en, mem_we} !== 8'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b required 00000000", {grant, rvalid, bounds_err, mem_en, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 50'b0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr %h wdata %h rdata %h required all 0", mem_addr, mem_wdata, rdata);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset_priority();
        req = 2'b11; req_we = 2'b00;
        req_addr = {18'h00002, 18'h00001};
        step();
        checks++;
        if ({grant, mem_en, mem_addr} !== {2'b01, 1'b1, 18'h00001}) begin
            errors++;
            $display("[TB] FAIL prio_grant0: got grant %b en %b addr %h required 01 1 00001", grant, mem_en, mem_addr);
        end
        step();
        checks++;
        if ({grant, mem_addr} !== {2'b10, 18'h00002}) begin
            errors++;
            $display("[TB] FAIL prio_grant1: got grant %b addr %h required 10 00002", grant, mem_addr);
        end
        step();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("[TB] FAIL prio_grant2: got %b required 01", grant);
        end
        req = '0;
        step();
        checks++;
        if ({grant, rvalid, rdata} !== {2'b00, 2'b01, 16'h0101}) begin
            errors++;
            $display("[TB] FAIL prio_rvalid0: got grant %b rvalid %b rdata %h required 00 01 0101", grant, rvalid, rdata);
        end
        step();
        checks++;
        if ({rvalid, rdata} !== {2'b10, 16'h0102}) begin
            errors++;
            $display("[TB] FAIL prio_rvalid1: got rvalid %b rdata %h required 10 0102", rvalid, rdata);
        end
        step();
        checks++;
        if ({rvalid, rdata} !== {2'b01, 16'h0101}) begin
            errors++;
            $display("[TB] FAIL prio_rvalid2: got rvalid %b rdata %h required 01 0101", rvalid, rdata);
        end
        idle(3);
    endtask

    task automatic test_single_requester();
        req = 2'b10; req_we = 2'b10;
        req_addr = {18'h00010, 18'h00000};
        req_wdata = {16'hBEEF, 16'h0000};
        step();
        checks++;
        if ({grant, mem_en, mem_we, mem_addr, mem_wdata} !== {2'b10, 1'b1, 1'b1, 18'h00010, 16'hBEEF}) begin
            errors++;
            $display("[TB] FAIL single_write: got grant %b en %b we %b addr %h wdata %h required 10 1 1 00010 beef",
                     grant, mem_en, mem_we, mem_addr, mem_wdata);
        end
        step();
        checks++;
        if ({grant, mem_en} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL single_mask: got grant %b en %b required 00 0", grant, mem_en);
        end
        step();
        checks++;
        if ({grant, mem_en} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL single_regrant: got grant %b en %b required 10 1", grant, mem_en);
        end
        req = '0; req_we = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (rvalid !== 2'b00) begin
                errors++;
                $display("[TB] FAIL single_no_rvalid: got %b required 00", rvalid);
            end
        end
    endtask

    task automatic test_read_routing();
        req = 2'b01; req_we = 2'b00;
        req_addr = {18'h00006, 18'h00005};
        step();
        checks++;
        if ({grant, mem_addr} !== {2'b01, 18'h00005}) begin
            errors++;
            $display("[TB] FAIL route_issue0: got grant %b addr %h required 01 00005", grant, mem_addr);
        end
        req = 2'b10;
        step();
        checks++;
        if ({grant, mem_addr} !== {2'b10, 18'h00006}) begin
            errors++;
            $display("[TB] FAIL route_issue1: got grant %b addr %h required 10 00006", grant, mem_addr);
        end
        req = '0;
        step();
        checks++;
        if (rvalid !== 2'b00) begin
            errors++;
            $display("[TB] FAIL route_early: got rvalid %b required 00", rvalid);
        end
        step();
        checks++;
        if ({rvalid, rdata} !== {2'b01, 16'h0105}) begin
            errors++;
            $display("[TB] FAIL route_ret0: got rvalid %b rdata %h required 01 0105", rvalid, rdata);
        end
        step();
        checks++;
        if ({rvalid, rdata} !== {2'b10, 16'h0106}) begin
            errors++;
            $display("[TB] FAIL route_ret1: got rvalid %b rdata %h required 10 0106", rvalid, rdata);
        end
        idle(3);
    endtask

    task automatic test_flush();
        req = 2'b11; req_we = 2'b00;
        req_addr = {18'h00030, 18'h00020};
        step();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush_issue0: got grant %b required 01", grant);
        end
        step();
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("[TB] FAIL flush_issue1: got grant %b required 10", grant);
        end
        req = '0;
        step();
        flush = 2'b10;
        step();
        flush = 2'b00;
        checks++;
        if ({rvalid, rdata} !== {2'b01, 16'h0120}) begin
            errors++;
            $display("[TB] FAIL flush_keep0: got rvalid %b rdata %h required 01 0120", rvalid, rdata);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rvalid !== 2'b00) begin
                errors++;
                $display("[TB] FAIL flush_drop1: got rvalid %b required 00", rvalid);
            end
        end
        req = 2'b10; flush = 2'b10;
        step();
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("[TB] FAIL flush_masks_req: got grant %b required 00", grant);
        end
        flush = 2'b00;
        step();
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("[TB] FAIL flush_release: got grant %b required 10", grant);
        end
        req = '0;
        step(); step();
        step();
        checks++;
        if ({rvalid, rdata} !== {2'b10, 16'h0130}) begin
            errors++;
            $display("[TB] FAIL flush_after: got rvalid %b rdata %h required 10 0130", rvalid, rdata);
        end
        idle(3);
    endtask

    task automatic test_bounds();
        alloc_valid = 2'b01;
        alloc_base = {16'h0000, 16'h0100};
        alloc_size = {16'h0000, 16'h0020};
`ifdef DELAY_MEM_BOUNDS_EN
        step();
        alloc_valid = '0;
        req = 2'b01; req_we = '0;
        req_addr = {18'h00000, 18'h0001F};
        step();
        checks++;
        if ({grant, mem_en, bounds_err, mem_addr} !== {2'b01, 1'b1, 2'b00, 18'h0011F}) begin
            errors++;
            $display("[TB] FAIL bounds_last_in: got grant %b en %b err %b addr %h required 01 1 00 0011f",
                     grant, mem_en, bounds_err, mem_addr);
        end
        req = '0;
        step();
        req = 2'b01;
        req_addr = {18'h00000, 18'h00020};
        step();
        checks++;
        if ({grant, mem_en, bounds_err} !== {2'b01, 1'b0, 2'b01}) begin
            errors++;
            $display("[TB] FAIL bounds_over: got grant %b en %b err %b required 01 0 01", grant, mem_en, bounds_err);
        end
        req = '0;
        step();
        checks++;
        if ({rvalid, rdata, bounds_err} !== {2'b01, 16'h021F, 2'b00}) begin
            errors++;
            $display("[TB] FAIL bounds_ret: got rvalid %b rdata %h err %b required 01 021f 00", rvalid, rdata, bounds_err);
        end
        step(); step();
        checks++;
        if (rvalid !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bounds_dropped_read: got rvalid %b required 00", rvalid);
        end
`else
        req = 2'b01; req_we = '0;
        req_addr = {18'h00000, 18'h00020};
        step();
        alloc_valid = '0;
        checks++;
        if ({grant, mem_en, bounds_err, mem_addr} !== {2'b01, 1'b1, 2'b00, 18'h00020}) begin
            errors++;
            $display("[TB] FAIL passthrough: got grant %b en %b err %b addr %h required 01 1 00 00020",
                     grant, mem_en, bounds_err, mem_addr);
        end
        req = '0;
        step(); step();
        step();
        checks++;
        if ({rvalid, rdata} !== {2'b01, 16'h0120}) begin
            errors++;
            $display("[TB] FAIL passthrough_ret: got rvalid %b rdata %h required 01 0120", rvalid, rdata);
        end
`endif
        idle(3);
    endtask

    task automatic test_reset_mid_read();
        req = 2'b01; req_we = '0;
        req_addr = {18'h00000, 18'h00040};
        step();
        checks++;
        if ({grant, mem_en} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL midreset_issue: got grant %b en %b required 01 1", grant, mem_en);
        end
        req = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rvalid !== 2'b00) begin
                errors++;
                $display("[TB] FAIL midreset_rvalid: got %b required 00", rvalid);
            end
            step();
        end
        req = 2'b11;
        step();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("[TB] FAIL midreset_priority: got grant %b required 01", grant);
        end
        idle(4);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_reset_priority();
        test_single_requester();
        test_read_routing();
        test_flush();
        test_bounds();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_mem_arbiter.md
# delay_mem_arbiter

Shares the single-port delay-line SRAM between the two pipelines, indexed as the control unit indexes them (0 = current, 1 = standby). Requesters are arbitrated round-robin, at most one memory access is issued per cycle, and read data is routed back to the requester that issued the read. The block sits between the pipelines' delay blocks and the SRAM port. It is configured by the `alloc_delay` / `delay_size_out` / `init_delay_out` outputs and `pipeline_full_reset` from the control unit.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (one per pipeline).
- `ADDR_WIDTH`, 18: SRAM word address width.
- `DATA_WIDTH`, 16: sample width.
- `MEM_LATENCY`, 2: SRAM read latency, in cycles from `mem_en` to valid `mem_rdata`. Minimum 1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N_REQ  access request per requester; held until granted.
- `req_we`  in  N_REQ  1 = write, 0 = read.
- `req_addr`  in  N_REQ*ADDR_WIDTH  address, packed with requester i at slice i.
- `req_wdata`  in  N_REQ*DATA_WIDTH  write data, packed.
- `grant`  out  N_REQ  one-hot pulse: request accepted.
- `rdata`  out  DATA_WIDTH  read data, shared by all requesters.
- `rvalid`  out  N_REQ  one-hot pulse: `rdata` belongs to requester i.
- `flush`  in  N_REQ  driven by `pipeline_full_reset`; discards the requester's in-flight reads.
- `mem_en`, `mem_we`  out  1 each  SRAM strobe and write enable.
- `mem_addr`  out  ADDR_WIDTH  SRAM address.
- `mem_wdata`  out  DATA_WIDTH  SRAM write data.
- `mem_rdata`  in  DATA_WIDTH  SRAM read data.
- `alloc_valid`  in  N_REQ  region load, one bit per requester (bounds build only).
- `alloc_size`  in  2*DATA_WIDTH  region size in words (bounds build only).
- `alloc_base`  in  2*DATA_WIDTH  region base in words (bounds build only).
- `bounds_err`  out  N_REQ  pulse: request dropped as out of range (bounds build only).

## Operation
- **Arbitration:** round-robin pointer `last`, reset to N_REQ-1, so requester 0 has first priority.
  - Search order is `last`+1, `last`+2, … modulo N_REQ.
  - The winner updates `last`.
  - The requester granted in the previous cycle is masked for one cycle, because its `req` is still high in that cycle.
- **Issue:** the winner's request is registered into the `mem_*` outputs.
  - `grant[i]` pulses in the same cycle that `mem_en` is high.
  - The requester must drop `req`, or present its next request, at the following edge.
- **Read return:** a tag shift register of depth MEM_LATENCY carries {valid, requester} for each issued read.
- **Flush:** `flush[i]` clears every valid tag with requester == i, and also masks `req[i]` in that cycle.
- **Reset values:** `grant`, `rvalid`, `bounds_err`, `mem_en` and `mem_we` = 0; `mem_addr`, `mem_wdata` and `rdata` = 0; tags cleared; `last` = N_REQ-1; region registers = 0. Reset asserted mid-operation discards all in-flight reads, so no `rvalid` follows.

## Timing
- `req` sampled at edge t → `grant` and `mem_en` high in cycle t+1.
- Read issued in cycle c → `rdata` and `rvalid` registered and high in cycle c+MEM_LATENCY+1.
- Throughput:
  - Two or more requesters active: one access per cycle, alternating between them.
  - Single requester: one access every 2 cycles, because of the post-grant mask.
- Simultaneous `flush[i]` and `rvalid` due for i in the same cycle: `flush` wins and `rvalid` is suppressed.
- Simultaneous `alloc_valid[i]` and `req[i]`: the request is checked against the old region; the new region applies from the next cycle.

## Configuration
`DELAY_MEM_BOUNDS_EN`:
- **Defined:**
  - A per-requester region {base, size} is loaded on `alloc_valid[i]`.
  - `req_addr` is an offset, and `mem_addr` = base + offset, truncated to ADDR_WIDTH.
  - An offset ≥ size is not issued: `grant[i]` still pulses, and `bounds_err[i]` pulses in the same cycle. A dropped read produces no `rvalid`.
  - Size 0 rejects every request.
- **Undefined:**
  - `req_addr` passes through unchanged as `mem_addr`.
  - The `alloc_*` inputs are ignored and `bounds_err` is tied to 0.

## Structure
- The shared package holds:
  - the tag struct typedef {valid, requester index};
  - the function computing the round-robin next index;
  - the constant `DELAY_ARB_MIN_LATENCY` = 1.
- Sub-module `rr_picker`: combinational round-robin selection, taking `req` masked and `last`, returning a one-hot winner. It is reused by the other arbiters.

## Test plan
- **Reset priority:** after reset, `req` = 2'b11, both reads → `grant` sequence 01, 10, 01. `rvalid[0]` appears MEM_LATENCY+1 cycles after the first grant.
- **Single requester:** `req[1]` held, write addr 0x10 data 0xBEEF → `mem_en`, `mem_we`, `mem_addr` 0x10, `mem_wdata` 0xBEEF. The next grant comes 2 cycles later.
- **Read routing:** requester 0 reads 0x5, then requester 1 reads 0x6, with the memory model returning addr+0x100 → `rvalid` 01 with `rdata` 0x105, then 10 with 0x106, on consecutive cycles.
- **Flush:** `flush[1]` asserted 1 cycle after requester 1's read issue → no `rvalid[1]`. Requester 0's reads are unaffected.
- **Bounds (BOUNDS_EN):** alloc base 0x100, size 0x20 for requester 0.
  - Offset 0x1F → `mem_addr` 0x11F.
  - Offset 0x20 → `bounds_err[0]` pulses, `mem_en` stays 0.
- **Reset mid-read:** assert `reset` in the cycle after a read issue → `rvalid` stays 0, and the first grant after reset goes to requester 0.
